alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_arb.sv | 117 +++++++++++
 tb/tb_alu_share_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Four-requester arbiter in front of a shared ALU with a fixed result latency of ALU_LAT cycles.
// Optional build macro ALU_SHARE_ARB_PRIO0_EN gives requester 0 strict priority over 1..3.
module alu_share_arb #(
  parameter int WIDTH   = 64,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_valid,
  output logic [3:0]         req_ready,
  input  logic [4*WIDTH-1:0] req_opa,
  input  logic [4*WIDTH-1:0] req_opb,
  input  logic [11:0]        req_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   alu_result,
  output logic               rsp_valid,
  output logic [1:0]         rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  input  logic               rsp_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

  state_t           state_q;
  logic [1:0]       rr_ptr_q;
  logic [1:0]       id_q;
  logic [2:0]       cnt_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_ctrl_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [1:0]       sel;
  logic [1:0]       idx;

  // Walk offsets high to low so the smallest offset from rr_ptr_q wins.
  always_comb begin
    sel = rr_ptr_q;
    idx = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr_q + 2'(k);
      if (req_valid[idx]) sel = idx;
    end
`ifdef ALU_SHARE_ARB_PRIO0_EN
    if (req_valid[0]) sel = 2'd0;
`endif
  end

  // Grant is combinational and suppressed while reset is held.
  always_comb begin
    req_ready = 4'b0000;
    if (rst_n && state_q == IDLE && |req_valid) req_ready[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd0;
      id_q        <= 2'd0;
      cnt_q       <= 3'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            alu_a_q    <= req_opa[sel*WIDTH +: WIDTH];
            alu_b_q    <= req_opb[sel*WIDTH +: WIDTH];
            alu_ctrl_q <= req_op[sel*3 +: 3];
            id_q       <= sel;
            cnt_q      <= LAT_M1;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            rsp_data_q  <= alu_result;
            rsp_valid_q <= 1'b1;
            cnt_q       <= 3'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= 3'd0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
`ifdef ALU_SHARE_ARB_PRIO0_EN
            if (id_q != 2'd0) rr_ptr_q <= id_q + 2'd1;
`else
            rr_ptr_q <= id_q + 2'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized scoreboard bench for alu_share_arb; an external ALU model stamps each result with the cycle number.
module tb_alu_share_arb;
  localparam int W   = 16;
  localparam int LAT = 4;
`ifdef ALU_SHARE_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     req_valid = 4'b0;
  logic [3:0]     req_ready;
  logic [4*W-1:0] req_opa, req_opb;
  logic [11:0]    req_op;
  logic [W-1:0]   alu_a, alu_b, alu_result, rsp_data;
  logic [2:0]     alu_ctrl;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] d;
  } exp_t;
  exp_t sbq[$];

  logic [3:0]   pend = 4'b0;
  logic [W-1:0] pa[4];
  logic [W-1:0] pb[4];
  logic [2:0]   po[4];

  bit           m_idle = 1'b1;
  int           m_rr = 0;
  int           m_g = 0;
  int           m_id = 0;
  logic [W-1:0] e_a = '0, e_b = '0;
  logic [2:0]   e_c = 3'd0;

  alu_share_arb #(.WIDTH(W), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_opa[i*W +: W] = pa[i];
      req_opb[i*W +: W] = pb[i];
      req_op[i*3 +: 3]  = po[i];
    end
  end

  // External ALU: an arbitrary operation mixed with the current cycle number.
  function automatic logic [W-1:0] alu_f(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] c, int t);
    logic [W-1:0] r;
    case (c)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: r = a;
    endcase
    return r ^ W'(t * 40503);
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_ctrl, cyc);

  function automatic int pick(logic [3:0] v, int rr);
    if (PRIO0 && v[0]) return 0;
    for (int k = 0; k < 4; k++) if (v[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " req_ready"}, req_ready, 0);
    chk({tag, " alu_a"}, alu_a, 0);
    chk({tag, " alu_b"}, alu_b, 0);
    chk({tag, " alu_ctrl"}, alu_ctrl, 0);
    chk({tag, " rsp_valid"}, rsp_valid, 0);
    chk({tag, " rsp_id"}, rsp_id, 0);
    chk({tag, " rsp_data"}, rsp_data, 0);
  endtask

  // One clock cycle: raise new requests, drive inputs, check grant/ALU/response flags, advance the model.
  task automatic step(input logic [3:0] newreq, input logic rdy);
    int w;
    bit inexec;
    exp_t e;
    logic [3:0] er;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!pend[i] && newreq[i]) begin
        pend[i] = 1'b1;
        pa[i] = W'($urandom);
        pb[i] = W'($urandom);
        po[i] = 3'($urandom_range(0, 7));
      end
    end
    req_valid = pend;
    rsp_ready = rdy;
    #1;
    w = m_idle ? pick(pend, m_rr) : -1;
    er = (w >= 0) ? 4'(1 << w) : 4'b0;
    chk("req_ready", req_ready, er);
    inexec = !m_idle && cyc > m_g && cyc <= m_g + LAT;
    chk("alu_a", alu_a, inexec ? e_a : 0);
    chk("alu_b", alu_b, inexec ? e_b : 0);
    chk("alu_ctrl", alu_ctrl, inexec ? e_c : 0);
    chk("rsp_valid", rsp_valid, !m_idle && cyc > m_g + LAT);
    if (w >= 0) begin
      m_idle = 1'b0;
      m_g = cyc;
      m_id = w;
      e_a = pa[w];
      e_b = pb[w];
      e_c = po[w];
      e.id = 2'(w);
      e.d = alu_f(pa[w], pb[w], po[w], cyc + LAT);
      sbq.push_back(e);
      pend[w] = 1'b0;
      $display("grant id=%0d a=%0h b=%0h op=%0d cycle=%0d", w, pa[w], pb[w], po[w], cyc);
    end else if (!m_idle && cyc > m_g + LAT && rdy) begin
      m_idle = 1'b1;
      if (!PRIO0 || m_id != 0) m_rr = (m_id + 1) % 4;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((!m_idle || pend != 4'b0) && n < 300) begin
      step(4'b0000, 1'b1);
      n++;
    end
    total++;
    if (!m_idle || pend != 4'b0) begin
      bad++;
      $display("FAIL drain: still busy after %0d cycles (idle=%0d pend=%b)", n, m_idle, pend);
    end
  endtask

  // Monitor: whenever a response is presented it must match the oldest expected entry; pop on acceptance.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rsp_valid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: id=%0d data=%0h with empty scoreboard at cycle %0d", rsp_id, rsp_data, cyc);
        end else begin
          chk("rsp_id", rsp_id, sbq[0].id);
          chk("rsp_data", rsp_data, sbq[0].d);
          if (rsp_ready) begin
            $display("rsp id=%0d data=%0h cycle=%0d", rsp_id, rsp_data, cyc);
            void'(sbq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    for (int i = 0; i < 4; i++) begin
      pa[i] = '0;
      pb[i] = '0;
      po[i] = 3'd0;
    end
    // Reset with requests present: everything must read zero.
    req_valid = 4'b1111;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Lone requester 3 from rr_ptr 0, then check the pointer wrapped back to 0.
    step(4'b1000, 1'b1);
    drain();
    step(4'b0011, 1'b1);
    drain();

    // All four held with immediate acceptance.
    for (int n = 0; n < 40; n++) step(4'b1111, 1'b1);
    drain();

    // Long response stall while requesters 1 and 2 wait.
    step(4'b0001, 1'b1);
    for (int n = 0; n < LAT + 11; n++) step(4'b0110, 1'b0);
    for (int n = 0; n < 3; n++) step(4'b0000, 1'b1);
    drain();

    // Random traffic with random back-pressure.
    for (int n = 0; n < 400; n++)
      step(4'($urandom) & 4'($urandom), $urandom_range(0, 3) != 0);
    drain();

    // Reset in the middle of EXEC abandons the operation.
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      step(4'b0001, 1'b1);
      if (!m_idle && cyc > m_g && cyc < m_g + LAT) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL mid_exec_wait: never reached EXEC within budget");
    end
    #2;
    rst_n = 1'b0;
    pend = 4'b0000;
    req_valid = 4'b0000;
    #1;
    chk_all_zero("async_reset");
    m_idle = 1'b1;
    m_rr = 0;
    sbq.delete();
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) step(4'b1111, 1'b1);
    drain();

    for (int n = 0; n < 150; n++)
      step(4'($urandom), $urandom_range(0, 1) != 0);
    drain();
    for (int n = 0; n < 3; n++) step(4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
